writeback_stage: RTL and testbench

- MEM/WB pipeline stage of the pipelined CPU, directly upstream of register_file.
- Accepts retiring instructions from the memory stage and waits for the data-memory response on loads.
- Formats load data (byte/half, signed/unsigned) and selects the result source.
- Drives register_file's reg_write_en / destination_reg / write_data, mirrors them as a forwarding bus, and raises stall while a load is outstanding.

---
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB stage: latches retiring instructions, waits out load responses, formats load data
// and drives the register-file write port plus an identical forwarding bus.
module writeback_stage #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [2:0]        in_load_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] destination_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              stall,
  output logic              load_timeout_err
);

  localparam int CNT_W = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    COMMIT   = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t            state_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic              accept;
  logic              load_wait;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] load_data_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;

  assign in_ready  = (state_q != WAIT_RSP);
  assign stall     = (state_q == WAIT_RSP);
  assign accept    = in_valid && in_ready;
  // A load that does not write rd never needs the response, so it commits immediately.
  assign load_wait = (in_wb_sel == 2'b01) && in_reg_write;
  assign result_d  = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
  assign cnt_d     = cnt_q + CNT_W'(1);

  always_comb begin
    byte_lane = mem_rsp_data[7:0];
    case (addr_lo_q)
      2'd1:    byte_lane = mem_rsp_data[15:8];
      2'd2:    byte_lane = mem_rsp_data[23:16];
      2'd3:    byte_lane = mem_rsp_data[31:24];
      default: byte_lane = mem_rsp_data[7:0];
    endcase
    half_lane = addr_lo_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
  end

  always_comb begin
    load_data_d = mem_rsp_data;
    case (funct3_q)
      3'b000:  load_data_d = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      3'b001:  load_data_d = {{(DATA_W-16){half_lane[15]}}, half_lane};
      3'b100:  load_data_d = {{(DATA_W-8){1'b0}}, byte_lane};
      3'b101:  load_data_d = {{(DATA_W-16){1'b0}}, half_lane};
      default: load_data_d = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY, COMMIT: begin
          if (accept) begin
            reg_write_q <= in_reg_write;
            rd_q        <= in_rd;
            funct3_q    <= in_load_funct3;
            addr_lo_q   <= in_addr_lo;
            cnt_q       <= '0;
            if (load_wait) begin
              state_q <= WAIT_RSP;
            end else begin
              data_q  <= result_d;
              state_q <= COMMIT;
            end
          end else begin
            state_q <= EMPTY;
          end
        end
        WAIT_RSP: begin
          // Response is checked first so it wins over a coincident timeout.
          if (mem_rsp_valid) begin
            data_q  <= load_data_d;
            state_q <= COMMIT;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            state_q <= EMPTY;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign reg_write_en     = (state_q == COMMIT) && reg_write_q && (rd_q != '0);
  assign destination_reg  = rd_q;
  assign write_data       = data_q;
  assign load_timeout_err = err_q;

  assign fwd_valid = reg_write_en;
  assign fwd_rd    = destination_reg;
  assign fwd_data  = write_data;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for single retirements, hand sequences
// for back-to-back commits, load timeout and reset during an outstanding load.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_load_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        reg_write_en;
  logic [4:0]  destination_reg;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        stall;
  logic        load_timeout_err;

  int checks;
  int errors;

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .LOAD_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_reg_write     (in_reg_write),
    .in_rd            (in_rd),
    .in_wb_sel        (in_wb_sel),
    .in_alu_result    (in_alu_result),
    .in_pc_plus4      (in_pc_plus4),
    .in_load_funct3   (in_load_funct3),
    .in_addr_lo       (in_addr_lo),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .reg_write_en     (reg_write_en),
    .destination_reg  (destination_reg),
    .write_data       (write_data),
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data),
    .stall            (stall),
    .load_timeout_err (load_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model downstream of the stage.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reg_write_en) rf[destination_reg] <= write_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  wb_sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] rsp;
    int          dly;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        chk_data;
  } vec_t;

  vec_t vt [24];
  int   nv;

  task automatic add(input logic [1:0] wb_sel, input logic rw, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                     input logic [1:0] alo, input logic [31:0] rsp, input int dly,
                     input logic exp_we, input logic [31:0] exp_data, input logic chk_data);
    vt[nv] = '{wb_sel, rw, rd, alu, pc4, f3, alo, rsp, dly, exp_we, exp_data, chk_data};
    nv++;
  endtask

  task automatic drive(input logic [1:0] wb_sel, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [2:0] f3, input logic [1:0] alo);
    in_valid       = 1'b1;
    in_wb_sel      = wb_sel;
    in_reg_write   = rw;
    in_rd          = rd;
    in_alu_result  = alu;
    in_load_funct3 = f3;
    in_addr_lo     = alo;
  endtask

  vec_t v;
  logic is_ld;

  initial begin
    checks = 0; errors = 0; nv = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_wb_sel = '0;
    in_alu_result = '0; in_pc_plus4 = '0; in_load_funct3 = '0; in_addr_lo = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_we", reg_write_en, 0);
    chk("rst_rd", destination_reg, 0);
    chk("rst_data", write_data, 0);
    chk("rst_err", load_timeout_err, 0);
    rst = 1'b0;

    //   wb  rw  rd  alu           pc4           f3      alo  rsp           dly we  data          chk
    add(2'b00, 1, 1, 32'd100,      32'h0,        3'b000, 0, 32'h0,          0, 1, 32'd100,      1);
    add(2'b01, 1, 5, 32'h0,        32'h0,        3'b000, 3, 32'h80FF_0000,  3, 1, 32'hFFFF_FF80, 1);
    add(2'b01, 1, 6, 32'h0,        32'h0,        3'b100, 3, 32'h80FF_0000,  3, 1, 32'h0000_0080, 1);
    add(2'b01, 1, 7, 32'h0,        32'h0,        3'b101, 2, 32'h80FF_0000,  3, 1, 32'h0000_80FF, 1);
    add(2'b01, 1, 8, 32'h0,        32'h0,        3'b101, 3, 32'h80FF_0000,  1, 1, 32'h0000_80FF, 1);
    add(2'b01, 1, 12, 32'h0,       32'h0,        3'b001, 2, 32'h80FF_0000,  2, 1, 32'hFFFF_80FF, 1);
    add(2'b01, 1, 13, 32'h0,       32'h0,        3'b000, 2, 32'h80FF_0000,  1, 1, 32'hFFFF_FFFF, 1);
    add(2'b01, 1, 14, 32'h0,       32'h0,        3'b010, 0, 32'h80FF_0000,  2, 1, 32'h80FF_0000, 1);
    add(2'b01, 1, 15, 32'h0,       32'h0,        3'b011, 1, 32'h80FF_0000,  4, 1, 32'h80FF_0000, 1);
    add(2'b01, 1, 16, 32'h0,       32'h0,        3'b001, 0, 32'h1234_8765,  1, 1, 32'hFFFF_8765, 1);
    add(2'b01, 1, 17, 32'h0,       32'h0,        3'b000, 1, 32'h1234_8765,  2, 1, 32'hFFFF_FF87, 1);
    add(2'b01, 1, 18, 32'h0,       32'h0,        3'b100, 2, 32'h1234_8765,  1, 1, 32'h0000_0034, 1);
    add(2'b01, 1, 19, 32'h0,       32'h0,        3'b001, 3, 32'h1234_8765,  1, 1, 32'h0000_1234, 1);
    add(2'b10, 1, 20, 32'h5555,    32'h0000_1004, 3'b000, 0, 32'h0,         0, 1, 32'h0000_1004, 1);
    add(2'b11, 1, 21, 32'hCAFE_0001, 32'h0000_2004, 3'b000, 0, 32'h0,       0, 1, 32'hCAFE_0001, 1);
    add(2'b00, 1, 0, 32'hDEAD_BEEF, 32'h0,       3'b000, 0, 32'h0,          0, 0, 32'hDEAD_BEEF, 1);
    add(2'b00, 0, 22, 32'h0000_0777, 32'h0,      3'b000, 0, 32'h0,          0, 0, 32'h0000_0777, 1);
    add(2'b01, 0, 23, 32'h0000_0999, 32'h0,      3'b010, 0, 32'h0,          0, 0, 32'h0,         0);

    for (int i = 0; i < nv; i++) begin
      v = vt[i];
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      drive(v.wb_sel, v.rw, v.rd, v.alu, v.f3, v.alo);
      in_pc_plus4  = v.pc4;
      mem_rsp_data = v.rsp;
      @(negedge clk);
      in_valid = 1'b0;
      is_ld = (v.wb_sel == 2'b01) && v.rw;
      if (is_ld) begin
        for (int k = 1; k <= v.dly; k++) begin
          if (k > 1) @(negedge clk);
          chk($sformatf("v%0d_stall_c%0d", i, k), stall, 1);
          chk($sformatf("v%0d_we_wait_c%0d", i, k), reg_write_en, 0);
          if (k == v.dly) mem_rsp_valid = 1'b1;
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
      chk($sformatf("v%0d_we", i), reg_write_en, v.exp_we);
      chk($sformatf("v%0d_rd", i), destination_reg, v.rd);
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid, v.exp_we);
      chk($sformatf("v%0d_fwd_rd", i), fwd_rd, v.rd);
      if (v.chk_data) begin
        chk($sformatf("v%0d_data", i), write_data, v.exp_data);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, v.exp_data);
      end
      chk($sformatf("v%0d_stall_done", i), stall, 0);
      @(negedge clk);
      chk($sformatf("v%0d_we_one_cycle", i), reg_write_en, 0);
      if (v.exp_we) chk($sformatf("v%0d_rf", i), rf[v.rd], v.exp_data);
    end
    chk("x0_reads_zero", rf[0], 0);
    chk("no_write_rd22", rf[22], 0);
    chk("no_write_rd23", rf[23], 0);

    // Back-to-back ALU commits.
    @(negedge clk);
    in_pc_plus4 = '0;
    drive(2'b00, 1, 5'd2, 32'h22, 3'b000, 0);
    @(negedge clk);
    chk("b2b_we0", reg_write_en, 1); chk("b2b_rd0", fwd_rd, 2); chk("b2b_d0", fwd_data, 32'h22);
    chk("b2b_rdy0", in_ready, 1);
    drive(2'b00, 1, 5'd3, 32'h33, 3'b000, 0);
    @(negedge clk);
    chk("b2b_we1", reg_write_en, 1); chk("b2b_rd1", fwd_rd, 3); chk("b2b_d1", fwd_data, 32'h33);
    chk("b2b_rdy1", in_ready, 1);
    drive(2'b00, 1, 5'd4, 32'h44, 3'b000, 0);
    @(negedge clk);
    chk("b2b_we2", reg_write_en, 1); chk("b2b_rd2", fwd_rd, 4); chk("b2b_d2", fwd_data, 32'h44);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_we", reg_write_en, 0);
    chk("b2b_hold_rd", destination_reg, 4);
    chk("b2b_hold_data", write_data, 32'h44);
    chk("b2b_rf2", rf[2], 32'h22); chk("b2b_rf3", rf[3], 32'h33); chk("b2b_rf4", rf[4], 32'h44);

    // Load timeout with LOAD_TIMEOUT=4.
    @(negedge clk);
    drive(2'b01, 1, 5'd9, 32'h0, 3'b010, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_stall_c%0d", k), stall, 1);
      chk($sformatf("to_err_c%0d", k), load_timeout_err, 0);
      @(negedge clk);
    end
    chk("to_stall_end", stall, 0);
    chk("to_err_set", load_timeout_err, 1);
    chk("to_in_ready", in_ready, 1);
    chk("to_we", reg_write_en, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hABCD_0123;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("to_late_we", reg_write_en, 0);
    @(negedge clk);
    chk("to_late_we2", reg_write_en, 0);
    chk("to_rf9", rf[9], 0);
    drive(2'b00, 1, 5'd11, 32'h55, 3'b000, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("to_after_we", reg_write_en, 1);
    chk("to_err_sticky", load_timeout_err, 1);

    // Reset while a load is outstanding.
    @(negedge clk);
    drive(2'b01, 1, 5'd10, 32'h0, 3'b010, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_stall_before", stall, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_stall", stall, 0);
    chk("rm_in_ready", in_ready, 1);
    chk("rm_we", reg_write_en, 0);
    chk("rm_rd", destination_reg, 0);
    chk("rm_data", write_data, 0);
    chk("rm_fwd_valid", fwd_valid, 0);
    chk("rm_err", load_timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rm_late_we", reg_write_en, 0);
    chk("rm_late_stall", stall, 0);
    @(negedge clk);
    chk("rm_late_we2", reg_write_en, 0);
    chk("rm_rf10", rf[10], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
